// File: rtl/oci_trace_pkg.sv
// Shared types and constants for the OCI debug-trace capture block.
package oci_trace_pkg;

    localparam int unsigned DEF_DATA_W  = 30;
    localparam int unsigned DEF_COUNT_W = 4;

    localparam int unsigned MODE_DROP = 0;
    localparam int unsigned MODE_WRAP = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Trace entry at the default widths, as seen on rd_data.
    typedef struct packed {
        logic [DEF_COUNT_W-1:0] count;
        logic [DEF_DATA_W-1:0]  buffer;
    } entry_t;

endpackage

// File: rtl/oci_trace_fifo.sv
// Circular trace FIFO with show-ahead registered read port, flush,
// and a drop-newest or overwrite-oldest policy when full.
module oci_trace_fifo
    import oci_trace_pkg::*;
#(
    parameter int unsigned ENTRY_W   = 34,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WRAP_MODE = MODE_DROP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ENTRY_W-1:0]       wdata,
    output logic [ENTRY_W-1:0]       rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_pulse_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [ENTRY_W-1:0] rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               wr_en_c, rd_adv_c, lvl_inc_c, pop_ok_c, full_c;

    // Policy decode, pointer/level update and next show-ahead word.
    always_comb begin
        wr_en_c     = 1'b0;
        lvl_inc_c   = 1'b0;
        ovf_pulse_c = 1'b0;
        full_c      = (level_q == LW'(DEPTH));
        pop_ok_c    = pop && (level_q != '0) && !flush;
        rd_adv_c    = pop_ok_c;

        if (!flush && push) begin
            if (!full_c || pop_ok_c) begin
                wr_en_c   = 1'b1;
                lvl_inc_c = 1'b1;
            end else if (WRAP_MODE == MODE_WRAP) begin
                wr_en_c     = 1'b1;
                rd_adv_c    = 1'b1;
                ovf_pulse_c = 1'b1;
            end else begin
                ovf_pulse_c = 1'b1;
            end
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(wr_en_c);
            rd_ptr_d = rd_ptr_q + AW'(rd_adv_c);
            level_d  = level_q + LW'(lvl_inc_c) - LW'(pop_ok_c);
        end

        // Bypass the write when the new head is the slot being written.
        rd_valid_d = (level_d != '0);
        if (level_d == '0) begin
            rd_data_d = '0;
        end else if (wr_en_c && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = wdata;
        end else begin
            rd_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign level    = level_q;

endmodule

// File: rtl/oci_dct_trace_capture.sv
// Samples the CPU DCT buffer on each count change into a trace FIFO,
// with capture/drain/done sequencing and a saturating overflow counter.
module oci_dct_trace_capture
    import oci_trace_pkg::*;
#(
    parameter int unsigned DATA_W    = 30,
    parameter int unsigned COUNT_W   = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WRAP_MODE = 0,
    parameter int unsigned OVF_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        capture_en,
    input  logic [DATA_W-1:0]           dct_buffer,
    input  logic [COUNT_W-1:0]          dct_count,
    input  logic                        test_ending,
    input  logic                        test_has_ended,
    output logic [COUNT_W+DATA_W-1:0]   rd_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [$clog2(DEPTH):0]      level,
    output logic [OVF_W-1:0]            overflow_cnt,
    output logic                        done,
    output logic [1:0]                  state_o
);

    localparam int unsigned ENTRY_W = COUNT_W + DATA_W;

    state_e              state_q, state_d;
    logic [COUNT_W-1:0]  prev_count_q, prev_count_d;
    logic [OVF_W-1:0]    ovf_cnt_q, ovf_cnt_d;
    logic                done_q, done_d;
    logic                push_req_c, pop_c, flush_c, ovf_pulse_c;

    // Sequencing, change detection and overflow accounting.
    always_comb begin
        state_d      = state_q;
        flush_c      = 1'b0;
        prev_count_d = dct_count;
        pop_c        = rd_valid && rd_ready;
        push_req_c   = (state_q == ST_CAPTURE) && (dct_count != prev_count_q)
                       && !test_ending;

        unique case (state_q)
            ST_IDLE:    if (capture_en)     state_d = ST_CAPTURE;
            ST_CAPTURE: if (test_ending)    state_d = ST_DRAIN;
            ST_DRAIN:   if (level == '0)    state_d = ST_DONE;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase

        if (test_has_ended) begin
            state_d = ST_DONE;
            flush_c = 1'b1;
        end

        ovf_cnt_d = ovf_cnt_q;
        if (ovf_pulse_c && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
        end

        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prev_count_q <= '0;
            ovf_cnt_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_count_q <= prev_count_d;
            ovf_cnt_q    <= ovf_cnt_d;
            done_q       <= done_d;
        end
    end

    oci_trace_fifo #(
        .ENTRY_W   (ENTRY_W),
        .DEPTH     (DEPTH),
        .WRAP_MODE (WRAP_MODE)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush_c),
        .push        (push_req_c),
        .pop         (pop_c),
        .wdata       ({dct_count, dct_buffer}),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .level       (level),
        .ovf_pulse_c (ovf_pulse_c)
    );

    assign overflow_cnt = ovf_cnt_q;
    assign done         = done_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_oci_dct_trace_capture.sv
// Scoreboard bench: a drop-mode and a wrap-mode instance share stimulus;
// expected pops are queued per instance and checked by a negedge monitor.
module tb_oci_dct_trace_capture;
    import oci_trace_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        capture_en;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
    logic        rd_ready;

    logic [33:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic [4:0]  level0, level1;
    logic [15:0] ovf0, ovf1;
    logic        done0, done1;
    logic [1:0]  state0, state1;

    int n_cmp = 0;
    int n_err = 0;
    entry_t q0[$];
    entry_t q1[$];

    always #5 clk = ~clk;

    oci_dct_trace_capture #(.DATA_W(30), .COUNT_W(4), .DEPTH(16), .WRAP_MODE(0), .OVF_W(16)) dut0 (
        .clk(clk), .reset(reset), .capture_en(capture_en), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready), .level(level0),
        .overflow_cnt(ovf0), .done(done0), .state_o(state0));

    oci_dct_trace_capture #(.DATA_W(30), .COUNT_W(4), .DEPTH(16), .WRAP_MODE(1), .OVF_W(16)) dut1 (
        .clk(clk), .reset(reset), .capture_en(capture_en), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ready(rd_ready), .level(level1),
        .overflow_cnt(ovf1), .done(done1), .state_o(state1));

    function automatic entry_t ent(input int k);
        entry_t e;
        e.count  = 4'(k);
        e.buffer = 30'(k);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_both(input int k);
        q0.push_back(ent(k));
        q1.push_back(ent(k));
    endtask

    task automatic push_step(input int k);
        dct_count  = 4'(k);
        dct_buffer = 30'(k);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        capture_en = 0; dct_buffer = '0; dct_count = '0;
        test_ending = 0; test_has_ended = 0; rd_ready = 0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_capture();
        capture_en = 1'b1;
        tick();
        capture_en = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) tick();
        rd_ready = 1'b0;
    endtask

    // Monitor: every accepted word must match the head of its queue.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (!reset && rd_valid0 && rd_ready) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_err++;
                    $display("FAIL pop0: unexpected word %0h", rd_data0);
                end else begin
                    e = q0.pop_front();
                    if (rd_data0 !== e) begin
                        n_err++;
                        $display("FAIL pop0: got %0h expected %0h", rd_data0, e);
                    end
                end
            end
            if (!reset && rd_valid1 && rd_ready) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL pop1: unexpected word %0h", rd_data1);
                end else begin
                    e = q1.pop_front();
                    if (rd_data1 !== e) begin
                        n_err++;
                        $display("FAIL pop1: got %0h expected %0h", rd_data1, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        do_reset();
        chk("rst_level", 64'(level0), 0);
        chk("rst_valid", 64'(rd_valid0), 0);
        chk("rst_data", 64'(rd_data0), 0);
        chk("rst_state", 64'(state0), 0);
        chk("rst_done", 64'(done0), 0);
        chk("rst_ovf", 64'(ovf0), 0);

        // Basic capture then in-order readout.
        start_capture();
        chk("cap_state", 64'(state0), 1);
        for (int k = 1; k <= 3; k++) push_step(k);
        chk("basic_level0", 64'(level0), 3);
        chk("basic_level1", 64'(level1), 3);
        chk("basic_head", 64'(rd_data0), 64'(ent(1)));
        for (int k = 1; k <= 3; k++) expect_both(k);
        drain(3);
        chk("basic_empty", 64'(level0), 0);
        chk("basic_valid", 64'(rd_valid0), 0);

        // Full: drop-newest vs overwrite-oldest.
        do_reset();
        start_capture();
        for (int k = 1; k <= 20; k++) push_step(k);
        chk("drop_level", 64'(level0), 16);
        chk("drop_ovf", 64'(ovf0), 4);
        chk("wrap_level", 64'(level1), 16);
        chk("wrap_ovf", 64'(ovf1), 4);
        for (int k = 1; k <= 16; k++) q0.push_back(ent(k));
        for (int k = 5; k <= 20; k++) q1.push_back(ent(k));
        drain(16);
        chk("full_drained", 64'(level1), 0);

        // Full with simultaneous push and pop.
        do_reset();
        start_capture();
        for (int k = 1; k <= 16; k++) push_step(k);
        chk("pp_full", 64'(level0), 16);
        expect_both(1);
        rd_ready = 1'b1;
        push_step(17);
        rd_ready = 1'b0;
        chk("pp_level0", 64'(level0), 16);
        chk("pp_level1", 64'(level1), 16);
        chk("pp_ovf0", 64'(ovf0), 0);
        chk("pp_ovf1", 64'(ovf1), 0);
        for (int k = 2; k <= 17; k++) expect_both(k);
        drain(16);

        // Drain sequence; the change alongside test_ending is not stored.
        do_reset();
        start_capture();
        for (int k = 1; k <= 5; k++) push_step(k);
        test_ending = 1'b1;
        push_step(6);
        chk("drain_state", 64'(state0), 2);
        chk("drain_level", 64'(level0), 5);
        for (int k = 1; k <= 5; k++) expect_both(k);
        drain(5);
        chk("drain_notyet", 64'(done0), 0);
        tick();
        chk("drain_done", 64'(done0), 1);
        chk("drain_state3", 64'(state1), 3);
        test_ending = 1'b0;

        // Abort with entries stored; DONE is terminal.
        do_reset();
        start_capture();
        for (int k = 1; k <= 7; k++) push_step(k);
        chk("abort_pre", 64'(level0), 7);
        test_has_ended = 1'b1;
        push_step(8);
        test_has_ended = 1'b0;
        chk("abort_level", 64'(level0), 0);
        chk("abort_valid", 64'(rd_valid1), 0);
        chk("abort_done", 64'(done0), 1);
        capture_en = 1'b1;
        tick();
        capture_en = 1'b0;
        chk("abort_stay", 64'(state0), 3);

        // Async reset mid-capture, checked before any clock edge.
        do_reset();
        start_capture();
        for (int k = 1; k <= 18; k++) push_step(k);
        chk("pre_rst_ovf", 64'(ovf0), 2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_level", 64'(level0), 0);
        chk("arst_valid", 64'(rd_valid0), 0);
        chk("arst_data", 64'(rd_data1), 0);
        chk("arst_ovf", 64'(ovf1), 0);
        chk("arst_state", 64'(state0), 0);
        chk("arst_done", 64'(done0), 0);
        tick();
        reset = 1'b0;
        tick();

        chk("q0_empty", 64'(q0.size()), 0);
        chk("q1_empty", 64'(q1.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
